// File: rtl/macro_test_seq.sv
// macro_test_seq: applies a stream of test vectors to a macro and scores each response.
//
// Each vector is fetched over a valid/ready handshake, driven onto the macro for
// wait_cycles+1 settle cycles, then the macro response is compared against the
// expected value in a single capture cycle. A run ends with a one-cycle done pulse
// after the vector flagged last, or silently on abort. Results hold until the next
// accepted start.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             begin a run (IDLE only), cancel a run (non-IDLE only)
//   wait_cycles              settle cycles per vector, latched on start
//   vec_valid/ready/data/exp/last  vector stream handshake and payload
//   mac_en, mac_din, mac_dout      macro enable, stimulus and response
//   busy, done, err          run active, end-of-run pulse, sticky failure flag
//   pass_cnt, fail_cnt       saturating pass/fail counters
//   vec_idx, first_fail      vectors completed (wrapping), index of first failure
module macro_test_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned WW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [WW-1:0] wait_cycles,
  input  logic          vec_valid,
  input  logic [DW-1:0] vec_data,
  input  logic [DW-1:0] vec_exp,
  input  logic          vec_last,
  output logic          vec_ready,
  output logic          mac_en,
  output logic [DW-1:0] mac_din,
  input  logic [DW-1:0] mac_dout,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    pass_cnt,
  output logic [7:0]    fail_cnt,
  output logic [7:0]    vec_idx,
  output logic [7:0]    first_fail
);

  typedef enum logic [2:0] {StIdle, StFetch, StDrive, StCapture, StDone} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_cfg_q, wait_cfg_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] exp_q, exp_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [7:0]    pass_q, pass_d;
  logic [7:0]    fail_q, fail_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    first_q, first_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cfg_q <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      exp_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      pass_q     <= 8'h00;
      fail_q     <= 8'h00;
      idx_q      <= 8'h00;
      first_q    <= 8'hFF;
    end else begin
      wait_cfg_q <= wait_cfg_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      exp_q      <= exp_d;
      last_q     <= last_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cfg_d = wait_cfg_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    exp_d      = exp_q;
    last_d     = last_q;
    err_d      = err_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    idx_d      = idx_q;
    first_d    = first_q;
    vec_ready  = 1'b0;
    mac_en     = 1'b0;
    mac_din    = '0;
    busy       = 1'b1;
    done       = 1'b0;

    // Outputs are a pure decode of the state so reset clears them without a clock.
    unique case (state_q)
      StIdle:    busy = 1'b0;
      StFetch:   vec_ready = 1'b1;
      StDrive,
      StCapture: begin
        mac_en  = 1'b1;
        mac_din = data_q;
      end
      StDone:    done = 1'b1;
      default:   busy = 1'b0;
    endcase

    // Abort wins over any handshake or scoring in the same cycle; results are kept.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pass_d     = 8'h00;
            fail_d     = 8'h00;
            idx_d      = 8'h00;
            err_d      = 1'b0;
            first_d    = 8'hFF;
            wait_cfg_d = wait_cycles;
            state_d    = StFetch;
          end
        end
        StFetch: begin
          if (vec_valid) begin
            data_d  = vec_data;
            exp_d   = vec_exp;
            last_d  = vec_last;
            cnt_d   = wait_cfg_q;
            state_d = StDrive;
          end
        end
        StDrive: begin
          if (cnt_q == '0) begin
            state_d = StCapture;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StCapture: begin
          if (mac_dout == exp_q) begin
            if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
          end else begin
            if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
            err_d = 1'b1;
            // err is still clear only up to the first failure of the run.
            if (!err_q) first_d = idx_q;
          end
          idx_d   = idx_q + 8'd1;
          state_d = last_q ? StDone : StFetch;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign err        = err_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign vec_idx    = idx_q;
  assign first_fail = first_q;

endmodule

// File: doc/macro_test_seq.md
MACRO_TEST_SEQ -- requirements
Module: macro_test_seq

Interface
REQ-001 SHALL have parameter DW, default 8, giving the macro data width in bits.
REQ-002 SHALL have parameter WW, default 4, giving the settle-wait counter width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  begin a test run; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous run cancel.
REQ-007 SHALL have port wait_cycles  input  WW  settle cycles per vector; sampled when start is accepted.
REQ-008 SHALL have ports vec_valid, vec_data, vec_exp and vec_last, each an input of width 1, DW, DW and 1: vector offer, stimulus, expected response, and final-vector flag.
REQ-009 SHALL have port vec_ready  output  1  vector accepted when vec_valid and vec_ready are both high.
REQ-010 SHALL have ports mac_en (output, 1), mac_din (output, DW) and mac_dout (input, DW): macro enable, macro stimulus and macro response.
REQ-011 SHALL have ports busy (output, 1), done (output, 1) and err (output, 1): run active, one-cycle end pulse, and sticky any-failure flag.
REQ-012 SHALL have ports pass_cnt (8), fail_cnt (8), vec_idx (8) and first_fail (8), all outputs: passing vectors, failing vectors, vectors completed, and index of the first failing vector.

Function
REQ-013 SHALL implement a state machine with states IDLE, FETCH, DRIVE, CAPTURE and DONE.
REQ-014 In IDLE, start=1 SHALL clear pass_cnt, fail_cnt, vec_idx, err and set first_fail=8'hFF, latch wait_cycles, then go to FETCH.
REQ-015 In FETCH, vec_ready SHALL be 1; on handshake it SHALL latch vec_data, vec_exp and vec_last, load the wait counter with the latched wait_cycles, and go to DRIVE.
REQ-016 vec_ready SHALL be 0 in every state other than FETCH.
REQ-017 In DRIVE and CAPTURE, mac_en SHALL be 1 and mac_din SHALL equal the latched vec_data; in all other states mac_en=0 and mac_din=0.
REQ-018 DRIVE SHALL decrement the wait counter each cycle and go to CAPTURE in the cycle the counter is 0, giving DRIVE a length of wait_cycles+1 cycles (1 cycle when wait_cycles=0).
REQ-019 In CAPTURE, if mac_dout equals the latched vec_exp, pass_cnt SHALL increment; otherwise fail_cnt SHALL increment and err SHALL be set.
REQ-020 In CAPTURE, on the first failure of a run, first_fail SHALL be loaded with the current vec_idx.
REQ-021 pass_cnt and fail_cnt SHALL saturate at 255.
REQ-022 vec_idx SHALL increment once per CAPTURE and wrap from 255 to 0.
REQ-023 From CAPTURE, the machine SHALL go to DONE if the latched last flag is 1, else to FETCH.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE; done SHALL be 0 at all other times.
REQ-025 busy SHALL be 1 in FETCH, DRIVE, CAPTURE and DONE, and 0 in IDLE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse; counters, err and first_fail SHALL retain their values; abort SHALL take priority over a simultaneous handshake or CAPTURE update.
REQ-028 Results SHALL hold after DONE or abort until the next accepted start.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and set vec_ready=0, mac_en=0, mac_din=0, busy=0, done=0, err=0, pass_cnt=0, fail_cnt=0, vec_idx=0 and first_fail=8'hFF, independent of clk.
REQ-030 Reset asserted mid-run SHALL discard the in-flight vector; after release the block SHALL remain in IDLE until start.

Verification
REQ-031 Three vectors with mac_dout = vec_exp, wait_cycles=2 -> each DRIVE lasts 3 cycles, done pulses once, pass_cnt=3, fail_cnt=0, err=0, first_fail=FF.
REQ-032 Four vectors with the 2nd (idx 1) and 4th mismatching -> fail_cnt=2, pass_cnt=2, first_fail=1, err=1.
REQ-033 wait_cycles=0 with vec_valid held high -> vec_ready rises every 3 cycles (FETCH, DRIVE, CAPTURE).
REQ-034 300 passing vectors -> pass_cnt=255 (saturated), vec_idx=44 (wrapped).
REQ-035 abort asserted during DRIVE of vector 2 -> IDLE next cycle, no done pulse, pass_cnt=2, mac_en=0; start while busy has no effect.
REQ-036 rst asserted during CAPTURE -> all outputs immediately at reset values, with no clock edge required.
